// File: rtl/spi_slave_fsm_pkg.sv
// Shared types for the SPI slave front end: RAM command encoding, FSM states and frame size.
package spi_slave_fsm_pkg;

  localparam int MEM_WIDTH  = 8;
  localparam int FRAME_BITS = MEM_WIDTH + 2;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } control_e;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } spi_state_e;

endpackage

// File: rtl/spi_tx_serializer.sv
// Shifts one RAM read word out on MISO, MSB first, once per read-data frame.
module spi_tx_serializer #(
  parameter int MEM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 arm,
  input  logic                 tx_valid,
  input  logic [MEM_WIDTH-1:0] tx_data,
  output logic                 miso
);

  localparam int CNT_WIDTH = $clog2(MEM_WIDTH + 2);

  logic [MEM_WIDTH-1:0] shift_reg;
  logic [CNT_WIDTH-1:0] bits_left;
  logic                 loaded;

  // Only the first tx_valid inside the armed window is taken; later ones are ignored until the frame ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso      <= 1'b0;
      shift_reg <= '0;
      bits_left <= '0;
      loaded    <= 1'b0;
    end else if (clear) begin
      miso      <= 1'b0;
      shift_reg <= '0;
      bits_left <= '0;
      loaded    <= 1'b0;
    end else if (arm && tx_valid && !loaded) begin
      miso      <= 1'b0;
      shift_reg <= tx_data;
      bits_left <= CNT_WIDTH'(MEM_WIDTH);
      loaded    <= 1'b1;
    end else if (bits_left != '0) begin
      miso      <= shift_reg[MEM_WIDTH-1];
      shift_reg <= {shift_reg[MEM_WIDTH-2:0], 1'b0};
      bits_left <= bits_left - 1'b1;
    end else begin
      miso      <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_slave_fsm.sv
// SPI slave front end: deserialises MOSI frames into RAM command words and returns read data on MISO.
module spi_slave_fsm #(
  parameter int MEM_WIDTH = spi_slave_fsm_pkg::MEM_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [MEM_WIDTH+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [MEM_WIDTH-1:0] tx_data,
  input  logic                 tx_valid
);

  import spi_slave_fsm_pkg::*;

  localparam int FRAME_W   = MEM_WIDTH + 2;
  localparam int CNT_WIDTH = $clog2(MEM_WIDTH + 2);

  spi_state_e           state;
  spi_state_e           next_state;
  logic [CNT_WIDTH-1:0] bit_cnt;
  logic                 rd_addr_seen;
  logic                 shift_en;
  logic                 last_bit;
  logic                 tx_arm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // The path-select bit is consumed here and never reaches rx_data.
  always_comb begin
    next_state = state;
    if (SS_n) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE:      next_state = CHK_CMD;
        CHK_CMD:   next_state = MOSI ? (rd_addr_seen ? READ_DATA : READ_ADD) : WRITE;
        WRITE,
        READ_ADD,
        READ_DATA: next_state = state;
        default:   next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    shift_en = !SS_n && (state == WRITE || state == READ_ADD || state == READ_DATA)
               && (bit_cnt < CNT_WIDTH'(FRAME_W));
    last_bit = shift_en && (bit_cnt == CNT_WIDTH'(FRAME_W - 1));
    tx_arm   = !SS_n && (state == READ_DATA) && (bit_cnt == CNT_WIDTH'(FRAME_W));
  end

  // bit_cnt saturates at FRAME_W, which both blocks extra MOSI bits and opens the read-response window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      bit_cnt  <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (SS_n || state == IDLE || state == CHK_CMD) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        rx_data  <= {rx_data[FRAME_W-2:0], MOSI};
        bit_cnt  <= bit_cnt + 1'b1;
        rx_valid <= last_bit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                rd_addr_seen <= 1'b0;
    else if (last_bit && state == READ_ADD)    rd_addr_seen <= 1'b1;
    else if (last_bit && state == READ_DATA)   rd_addr_seen <= 1'b0;
  end

  spi_tx_serializer #(.MEM_WIDTH(MEM_WIDTH)) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (SS_n),
    .arm      (tx_arm),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .miso     (MISO)
  );

endmodule
